// File: rtl/alu_op_controller.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_controller
//  Brief    : Sequencing controller for the shared 3-bit ALU datapath.
//             Accepts one request over valid/ready, registers the operands,
//             drives the combinational datapath (OR/AND/ADD) and captures the
//             6-bit result. The result is held until the consumer takes it.
//             Build option ALU_MUL_EN: when defined, opcode 11 is a 3-cycle
//             shift-add multiply. When undefined, opcode 11 completes in one
//             cycle with result 0 and the error flag set.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_controller #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [2:0]       in_a,
    input  logic [2:0]       in_b,
    output logic [2:0]       dp_a,
    output logic [2:0]       dp_b,
    input  logic [5:0]       dp_or,
    input  logic [5:0]       dp_and,
    input  logic [5:0]       dp_add,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_result,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_EXEC   = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    localparam logic [1:0] c_OP_OR  = 2'b00;
    localparam logic [1:0] c_OP_AND = 2'b01;
    localparam logic [1:0] c_OP_ADD = 2'b10;
    localparam logic [1:0] c_OP_MUL = 2'b11;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [1:0]       r_op;
    logic [2:0]       r_a;
    logic [2:0]       r_b;
    logic [5:0]       r_result;
    logic             r_err;
    logic [CNT_W-1:0] r_count;
    logic [5:0]       w_result_next;
    logic             w_err_next;
    logic             w_exec_last;
    logic             w_accept;

    assign w_accept = (r_state == c_IDLE) && in_valid;

`ifdef ALU_MUL_EN
    logic [5:0] r_acc;
    logic [1:0] r_iter;
    logic       w_b_bit;
    logic [5:0] w_addend;
    logic [5:0] w_acc_next;

    // Multiplier bit for this iteration and the partial sum it contributes
    always_comb begin
        w_b_bit = 1'b0;
        case (r_iter)
            2'd0:    w_b_bit = r_b[0];
            2'd1:    w_b_bit = r_b[1];
            2'd2:    w_b_bit = r_b[2];
            default: w_b_bit = 1'b0;
        endcase
        w_addend   = w_b_bit ? ({3'b000, r_a} << r_iter) : 6'd0;
        w_acc_next = r_acc + w_addend;
    end

    // Accumulator and iteration counter; cleared on every accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= 6'd0;
            r_iter <= 2'd0;
        end else if (w_accept) begin
            r_acc  <= 6'd0;
            r_iter <= 2'd0;
        end else if ((r_state == c_EXEC) && (r_op == c_OP_MUL) && (r_iter != 2'd2)) begin
            r_acc  <= w_acc_next;
            r_iter <= r_iter + 2'd1;
        end
    end

    // Multiply stays in EXEC until the third iteration
    assign w_exec_last = (r_op != c_OP_MUL) || (r_iter == 2'd2);
`else
    // Every opcode finishes in a single EXEC cycle
    assign w_exec_last = 1'b1;
`endif

    // Result selection for the cycle that leaves EXEC
    always_comb begin
        w_result_next = 6'd0;
        w_err_next    = 1'b0;
        case (r_op)
            c_OP_OR:  w_result_next = dp_or;
            c_OP_AND: w_result_next = dp_and;
            c_OP_ADD: w_result_next = dp_add;
            c_OP_MUL: begin
`ifdef ALU_MUL_EN
                w_result_next = w_acc_next;
`else
                w_err_next    = 1'b1;
`endif
            end
            default:  w_result_next = 6'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)    w_state_next = c_EXEC;
            c_EXEC:  if (w_exec_last) w_state_next = c_DONE;
            c_DONE:  if (out_ready)   w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // State-decoded outputs; datapath operands are zero except in EXEC
    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
        dp_a      = (r_state == c_EXEC) ? r_a : 3'd0;
        dp_b      = (r_state == c_EXEC) ? r_b : 3'd0;
    end

    // Operand capture on acceptance, result capture on the last EXEC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 2'd0;
            r_a      <= 3'd0;
            r_b      <= 3'd0;
            r_result <= 6'd0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_op <= in_op;
            r_a  <= in_a;
            r_b  <= in_b;
        end else if ((r_state == c_EXEC) && w_exec_last) begin
            r_result <= w_result_next;
            r_err    <= w_err_next;
        end
    end

    // Completed-operation counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if ((r_state == c_DONE) && out_ready) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign out_result = r_result;
    assign out_err    = r_err;
    assign op_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_controller
//  Brief    : Directed self-checking bench for alu_op_controller. A second
//             instance with a 2-bit counter shares the stimulus to observe
//             op_count wrap. Expected MUL behaviour follows ALU_MUL_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_controller;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_op;
    logic [2:0] in_a;
    logic [2:0] in_b;
    logic       out_ready;

    logic       in_ready,  in_ready2;
    logic [2:0] dp_a,      dp_b,      dp_a2,     dp_b2;
    logic [5:0] dp_or,     dp_and,    dp_add;
    logic [5:0] dp_or2,    dp_and2,   dp_add2;
    logic       out_valid, out_valid2;
    logic [5:0] out_result, out_result2;
    logic       out_err,   out_err2;
    logic [7:0] op_count;
    logic [1:0] op_count2;

    int n_vec  = 0;
    int n_miss = 0;
    int n_ops  = 0;

    // Reference combinational datapaths
    assign dp_or   = {3'b000, dp_a | dp_b};
    assign dp_and  = {3'b000, dp_a & dp_b};
    assign dp_add  = {3'b000, dp_a} + {3'b000, dp_b};
    assign dp_or2  = {3'b000, dp_a2 | dp_b2};
    assign dp_and2 = {3'b000, dp_a2 & dp_b2};
    assign dp_add2 = {3'b000, dp_a2} + {3'b000, dp_b2};

    alu_op_controller #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .dp_a(dp_a), .dp_b(dp_b),
        .dp_or(dp_or), .dp_and(dp_and), .dp_add(dp_add),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_err(out_err),
        .op_count(op_count)
    );

    alu_op_controller #(.CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .dp_a(dp_a2), .dp_b(dp_b2),
        .dp_or(dp_or2), .dp_and(dp_and2), .dp_add(dp_add2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_result(out_result2), .out_err(out_err2),
        .op_count(op_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_cnt"},  32'(op_count),  32'(n_ops % 256));
        check({tag, "_cnt2"}, 32'(op_count2), 32'(n_ops % 4));
    endtask

    // Issue one request and check latency, result and error flag.
    // With out_ready high the handshake is also completed and checked.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] a,
                          input logic [2:0] b, input logic [5:0] exp_res,
                          input logic exp_err, input int exp_lat);
        int g;
        int lat;
        g = 0;
        while (!in_ready && g < 20) begin tick(); g++; end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0; in_op = ~op; in_a = ~a; in_b = ~b;
        check({tag, "_dpa"}, 32'(dp_a), 32'(a));
        check({tag, "_dpb"}, 32'(dp_b), 32'(b));
        lat = 0;
        while (!out_valid && lat < 10) begin tick(); lat++; end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, 32'(out_result), 32'(exp_res));
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        if (out_ready) begin
            tick();
            n_ops++;
            check({tag, "_vdrop"}, 32'(out_valid), 32'd0);
            check({tag, "_rdy"}, 32'(in_ready), 32'd1);
            check_counts(tag);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_a = 3'd0; in_b = 3'd0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_ready",  32'(in_ready),   32'd1);
        check("rst_valid",  32'(out_valid),  32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_dp",     32'({dp_a, dp_b}), 32'd0);
        check_counts("rst");
        rst_n = 1'b1;
        tick();

        // Logic ops with out_ready high
        run_op("or52",  2'b00, 3'd5, 3'd2, 6'd7,  1'b0, 1);
        run_op("and63", 2'b01, 3'd6, 3'd3, 6'd2,  1'b0, 1);
        run_op("add77", 2'b10, 3'd7, 3'd7, 6'd14, 1'b0, 1);

        // Reset in the middle of a multiply
        in_valid = 1'b1; in_op = 2'b11; in_a = 3'd7; in_b = 3'd7;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_ops = 0;
        check("mrst_ready",  32'(in_ready),   32'd1);
        check("mrst_valid",  32'(out_valid),  32'd0);
        check("mrst_result", 32'(out_result), 32'd0);
        check("mrst_err",    32'(out_err),    32'd0);
        check("mrst_dp",     32'({dp_a, dp_b}), 32'd0);
        check_counts("mrst");
        tick();
        rst_n = 1'b1;
        tick();
        run_op("or12", 2'b00, 3'd1, 3'd2, 6'd3, 1'b0, 1);

`ifdef ALU_MUL_EN
        run_op("mul77", 2'b11, 3'd7, 3'd7, 6'd49, 1'b0, 3);
        run_op("mul50", 2'b11, 3'd5, 3'd0, 6'd0,  1'b0, 3);
        run_op("mul36", 2'b11, 3'd3, 3'd6, 6'd18, 1'b0, 3);
`else
        run_op("mul77", 2'b11, 3'd7, 3'd7, 6'd0, 1'b1, 1);
        run_op("mul50", 2'b11, 3'd5, 3'd0, 6'd0, 1'b1, 1);
        run_op("mul36", 2'b11, 3'd3, 3'd6, 6'd0, 1'b1, 1);
`endif

        // Backpressure: result held, concurrent request ignored
        out_ready = 1'b0;
        run_op("add34", 2'b10, 3'd3, 3'd4, 6'd7, 1'b0, 1);
        in_valid = 1'b1; in_op = 2'b00; in_a = 3'd7; in_b = 3'd7;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid",  32'(out_valid),  32'd1);
            check("bp_result", 32'(out_result), 32'd7);
            check("bp_ready",  32'(in_ready),   32'd0);
        end
        check_counts("bp_hold");
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        n_ops++;
        check("bp_vdrop", 32'(out_valid), 32'd0);
        check_counts("bp_rel");
        tick();
        check("bp_noacc", 32'(out_valid), 32'd0);
        check("bp_idle",  32'(in_ready),  32'd1);
        check("wrap5",    32'(op_count2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
